// File: rtl/poly_song_reader.sv
// Song sequencer: walks a song ROM and emits per-voice note events, with
// pause, fast-forward, rewind and mid-song song switching.
module poly_song_reader #(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned VOICES    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [SONG_BITS-1:0]           song,
  input  logic                           ff_switch0,
  input  logic                           r_switch1,
  input  logic                           note_done,
  output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
  input  logic [15:0]                    rom_data,
  output logic [VOICES-1:0]              new_note,
  output logic [5:0]                     note,
  output logic [5:0]                     duration,
  output logic [2:0]                     parameters,
  output logic                           activate,
  output logic                           song_done
);

  localparam int unsigned VW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned AW = SONG_BITS + ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX   = '1;
  localparam logic [VW-1:0]        LAST_VOICE = VW'(VOICES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ROMWAIT, S_ISSUE, S_WAIT_DONE, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SONG_BITS-1:0]   song_q, song_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [VW-1:0]          voice_q, voice_d;
  logic                   pending_q, pending_d;
  logic                   armed_q, armed_d;
  logic [AW-1:0]          rom_addr_q, rom_addr_d;
  logic [VOICES-1:0]      new_note_q, new_note_d;
  logic [5:0]             note_q, note_d;
  logic [5:0]             dur_q, dur_d;
  logic [2:0]             par_q, par_d;
  logic                   activate_q, activate_d;
  logic                   song_done_q, song_done_d;
  logic                   to_fetch;
  logic                   at_bound;

  logic       e_adv;
  logic [5:0] e_note;
  logic [5:0] e_dur;
  logic [2:0] e_par;
  logic [5:0] e_half;

  assign e_adv  = rom_data[15];
  assign e_note = rom_data[14:9];
  assign e_dur  = rom_data[8:3];
  assign e_par  = rom_data[2:0];
  assign e_half = {1'b0, e_dur[5:1]};

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    idx_d       = idx_q;
    voice_d     = voice_q;
    pending_d   = pending_q;
    armed_d     = armed_q;
    new_note_d  = '0;
    note_d      = note_q;
    dur_d       = dur_q;
    par_d       = par_q;
    to_fetch    = 1'b0;
    at_bound    = 1'b0;

    if (!play) armed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (play && armed_q) begin
          state_d   = S_FETCH;
          song_d    = song;
          idx_d     = r_switch1 ? LAST_IDX : '0;
          voice_d   = '0;
          pending_d = 1'b0;
          armed_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (play) state_d = S_ROMWAIT;
      end
      S_ROMWAIT: state_d = S_ISSUE;
      S_ISSUE: begin
        if (e_note == 6'd0 && e_dur == 6'd0) begin
          state_d = S_DONE;
        end else begin
          new_note_d = VOICES'(1) << voice_q;
          note_d     = e_note;
          par_d      = e_par;
          if (ff_switch0 && !r_switch1) dur_d = (e_half == 6'd0) ? 6'd1 : e_half;
          else                          dur_d = e_dur;
          voice_d = (e_adv || voice_q == LAST_VOICE) ? '0 : voice_q + VW'(1);
          at_bound = r_switch1 ? (idx_q == '0) : (idx_q == LAST_IDX);
          // Stepping off either end of the table finishes the song; no wrap.
          if (at_bound) begin
            state_d = S_DONE;
          end else begin
            idx_d = r_switch1 ? idx_q - ADDR_BITS'(1) : idx_q + ADDR_BITS'(1);
            if (e_adv) state_d = S_WAIT_DONE;
            else       to_fetch = 1'b1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (play) begin
          if (note_done || pending_q) begin
            to_fetch  = 1'b1;
            pending_d = 1'b0;
          end
        end else if (note_done) begin
          pending_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new song selection takes effect on the next hop back to FETCH.
    if (to_fetch) begin
      state_d = S_FETCH;
      if (song != song_q) begin
        song_d  = song;
        idx_d   = r_switch1 ? LAST_IDX : '0;
        voice_d = '0;
      end
    end

    rom_addr_d  = {song_d, idx_d};
    activate_d  = (state_d != S_IDLE);
    song_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      song_q      <= '0;
      idx_q       <= '0;
      voice_q     <= '0;
      pending_q   <= 1'b0;
      armed_q     <= 1'b1;
      rom_addr_q  <= '0;
      new_note_q  <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      par_q       <= '0;
      activate_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      voice_q     <= voice_d;
      pending_q   <= pending_d;
      armed_q     <= armed_d;
      rom_addr_q  <= rom_addr_d;
      new_note_q  <= new_note_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      par_q       <= par_d;
      activate_q  <= activate_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign new_note   = new_note_q;
  assign note       = note_q;
  assign duration   = dur_q;
  assign parameters = par_q;
  assign activate   = activate_q;
  assign song_done  = song_done_q;

endmodule
